snn_config_loader: RTL and testbench

SNN_CONFIG_LOADER -- requirements
Module: snn_config_loader

---
 rtl/snn_config_loader.sv | 145 ++++++++++++++
 tb/tb_snn_config_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_config_loader.sv
// Byte-stream loader: receives SYNC/HDR/DATA[/CSUM] frames into a shadow buffer, then
// writes them to the network register file. Define CFG_CHECKSUM_EN to add the CSUM byte check.
module snn_config_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] addr,
    output logic [7:0] data_out,
    output logic       write_enable,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_error
);
    localparam logic [7:0] SYNC = 8'hA5;

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, COMMIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, DATA, COMMIT} state_t;
`endif

    state_t     state;
    logic [3:0] start_q;
    logic [3:0] count_q;
    logic [3:0] idx;
    logic [7:0] buffer [15];
`ifdef CFG_CHECKSUM_EN
    logic [7:0] sum_q;
`endif

    logic       accept;
    logic       hdr_bad;
    logic [3:0] next_idx;

    assign in_ready = (state != COMMIT);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign next_idx = idx + 4'd1;
    // 5-bit sum so that start+count overflowing the 4-bit address space is caught
    assign hdr_bad  = (in_data[3:0] == 4'd0) ||
                      (({1'b0, in_data[7:4]} + {1'b0, in_data[3:0]}) > 5'd15);

    // NOTE: the shadow buffer is a plain memory with no reset; stale contents are harmless
    // because COMMIT is only reachable after a complete new frame has overwritten them.
    always_ff @(posedge clk) begin
        if (!reset && state == DATA && accept)
            buffer[idx] <= in_data;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the same branch override the defaults.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            write_enable <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            addr         <= 4'd0;
            data_out     <= 8'd0;
            start_q      <= 4'd0;
            count_q      <= 4'd0;
            idx          <= 4'd0;
`ifdef CFG_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            write_enable <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && in_data == SYNC)
                        state <= HDR;
                end
                HDR: begin
                    if (accept) begin
                        start_q <= in_data[7:4];
                        count_q <= in_data[3:0];
                        idx     <= 4'd0;
`ifdef CFG_CHECKSUM_EN
                        sum_q   <= in_data;
`endif
                        if (hdr_bad) begin
                            frame_error <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        idx <= next_idx;
`ifdef CFG_CHECKSUM_EN
                        sum_q <= sum_q + in_data;
                        if (idx == count_q - 4'd1)
                            state <= CSUM;
`else
                        if (idx == count_q - 4'd1) begin
                            // First write goes out straight away; a one-byte frame is
                            // still landing in the buffer, so forward it directly.
                            state        <= COMMIT;
                            write_enable <= 1'b1;
                            addr         <= start_q;
                            data_out     <= (idx == 4'd0) ? in_data : buffer[0];
                            idx          <= 4'd0;
                        end
`endif
                    end
                end
`ifdef CFG_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            state        <= COMMIT;
                            write_enable <= 1'b1;
                            addr         <= start_q;
                            data_out     <= buffer[0];
                            idx          <= 4'd0;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
`endif
                COMMIT: begin
                    // idx is the entry currently on the register-file bus
                    if (next_idx == count_q) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        write_enable <= 1'b1;
                        addr         <= start_q + next_idx;
                        data_out     <= buffer[next_idx];
                        idx          <= next_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_config_loader.sv
// Scoreboard bench for snn_config_loader: the driver pushes expected register-file events
// computed from frame contents, a negedge monitor pops and compares them cycle-exactly.
module tb_snn_config_loader;
    localparam int W_EV = 0;
    localparam int D_EV = 1;
    localparam int E_EV = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] addr;
    logic [7:0] data_out;
    logic       write_enable;
    logic       busy;
    logic       frame_done;
    logic       frame_error;

    snn_config_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .addr         (addr),
        .data_out     (data_out),
        .write_enable (write_enable),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_writes = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic expect_event(input int kind, input int a, input int d, input int c);
        exp_q.push_back('{kind, a, d, c});
    endtask

    // Monitor: any register-file activity must match the head of the scoreboard.
    always @(negedge clk) begin
        int  kind;
        ev_t e;
        if (write_enable || frame_done || frame_error) begin
            kind = write_enable ? W_EV : (frame_done ? D_EV : E_EV);
            if (write_enable) n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", kind, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (e.kind == W_EV) begin
                    check("write_addr", int'(addr), e.addr);
                    check("write_data", int'(data_out), e.data);
                end
            end
        end
    end

    // Drive one byte (optionally after an in_valid gap); returns the edge count at which
    // it is accepted. The caller is left just before that edge.
    task automatic present(input logic [7:0] b, input bit gaps, output int acc);
        int n;
        n = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        acc = cyc + 1;
    endtask

    task automatic advance();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_busy", int'(busy), 0);
        check("pending_events", exp_q.size(), 0);
    endtask

    // Reference model: a valid header yields count writes at start+i on consecutive
    // cycles right after the last byte, then a done pulse; anything invalid yields one error.
    task automatic send_frame(input logic [3:0] start, input logic [3:0] count,
                              input logic [7:0] d[$], input logic [7:0] flip, input bit gaps);
        logic [7:0] hdr;
        logic [7:0] sum;
        int         acc;
        hdr = {start, count};
        sum = hdr;
        present(8'hA5, gaps, acc);
        advance();
        present(hdr, gaps, acc);
        if (count == 4'd0 || int'(start) + int'(count) > 15) begin
            expect_event(E_EV, 0, 0, acc);
            advance();
            wait_idle();
            return;
        end
        for (int i = 0; i < int'(count); i++) begin
            advance();
            present(d[i], gaps, acc);
            sum = sum + d[i];
        end
`ifdef CFG_CHECKSUM_EN
        advance();
        present(sum ^ flip, gaps, acc);
`endif
        if (flip != 8'h00) begin
            expect_event(E_EV, 0, 0, acc);
        end else begin
            for (int i = 0; i < int'(count); i++)
                expect_event(W_EV, int'(start) + i, int'(d[i]), acc + i);
            expect_event(D_EV, 0, 0, acc + int'(count));
        end
        advance();
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         acc;
        int         w0;
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] flip;
        logic [3:0] s;
        logic [3:0] c;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_write_enable", int'(write_enable), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_error", int'(frame_error), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // Three writes 0:80 1:10 2:02 (checksum 95 when enabled)
        q = '{8'h80, 8'h10, 8'h02};
        send_frame(4'd0, 4'd3, q, 8'h00, 1'b0);

        // start 6, nine bytes: fills addresses 6..14 exactly
        q = {};
        repeat (9) q.push_back(8'($urandom_range(0, 255)));
        send_frame(4'd6, 4'd9, q, 8'h00, 1'b0);

        // Header E2: 14+2 overflows the register file
        q = {};
        send_frame(4'd14, 4'd2, q, 8'h00, 1'b0);

        // Zero-length frame is rejected
        send_frame(4'd3, 4'd0, q, 8'h00, 1'b0);

`ifdef CFG_CHECKSUM_EN
        // 01 + 40 = 41, but 42 is sent
        q = '{8'h40};
        send_frame(4'd0, 4'd1, q, 8'h03, 1'b0);
`endif

        // Leading junk is discarded, then a frame arrives with in_valid gaps
        present(8'h00, 1'b1, acc);
        advance();
        present(8'h7F, 1'b1, acc);
        advance();
        q = '{8'h11, 8'h22};
        send_frame(4'd0, 4'd2, q, 8'h00, 1'b1);

        // Reset after the first of five commit writes: nothing further reaches the file
        w0 = n_writes;
        q  = {};
        repeat (5) q.push_back(8'($urandom_range(0, 255)));
        present(8'hA5, 1'b0, acc);
        advance();
        present(8'h05, 1'b0, acc);
        b = 8'h05;
        for (int i = 0; i < 5; i++) begin
            advance();
            present(q[i], 1'b0, acc);
            b = b + q[i];
        end
`ifdef CFG_CHECKSUM_EN
        advance();
        present(b, 1'b0, acc);
`endif
        expect_event(W_EV, 0, int'(q[0]), acc);
        advance();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_commit_writes", n_writes - w0, 1);
        check("reset_commit_addr", int'(addr), 0);
        check("reset_commit_data", int'(data_out), 0);
        wait_idle();

        // Randomized frames, mostly in range, with junk bytes and gaps in between
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h3C;
                present(b, 1'b1, acc);
                advance();
            end
            s = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0 && int'(s) + int'(c) > 15) s = 4'd15 - c;
            q = {};
            repeat (int'(c)) q.push_back(8'($urandom_range(0, 255)));
            flip = 8'h00;
`ifdef CFG_CHECKSUM_EN
            if ($urandom_range(0, 4) == 0) flip = 8'($urandom_range(1, 255));
`endif
            send_frame(s, c, q, flip, $urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge clk);
        check("final_pending_events", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
